// File: rtl/instruction_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_queue_pkg
// Shared definitions for the instruction fetch front end: data/address widths,
// the sequential PC step, the default reset PC, the fetch FSM state encoding
// and the {pc, inst} queue entry layout.
// No ports (package).
// ----------------------------------------------------------------------------
package instruction_fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DISCARD  = 2'd2
  } fetch_state_t;

  // 64-bit queue entry: PC in the upper half, instruction in the lower half.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Sequential successor PC; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/instr_queue_fifo.sv
// ----------------------------------------------------------------------------
// instr_queue_fifo
// Circular buffer of fetch entries with push, pop and clear.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (pointers and count to zero)
//   en         : global enable; when low nothing changes
//   clear      : empties the queue; overrides push and pop
//   push       : write push_entry at tail
//   pop        : advance head (caller guarantees queue is non-empty)
//   push_entry : entry to write
//   head_entry : entry at head (combinational read)
//   count      : number of valid entries (one bit wider than the pointers)
// ----------------------------------------------------------------------------
module instr_queue_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  assign head_entry = entries[head_ptr];

  // Entry storage: written at tail on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (en && push && !clear) begin
      entries[tail_ptr] <= push_entry;
    end
  end

  // Head/tail pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= {PTR_W{1'b0}};
      tail_ptr <= {PTR_W{1'b0}};
      count    <= {CNT_W{1'b0}};
    end else if (en) begin
      if (clear) begin
        head_ptr <= {PTR_W{1'b0}};
        tail_ptr <= {PTR_W{1'b0}};
        count    <= {CNT_W{1'b0}};
      end else begin
        if (push) begin
          tail_ptr <= tail_ptr + PTR_W'(1);
        end
        if (pop) begin
          head_ptr <= head_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// ----------------------------------------------------------------------------
// instruction_fetch_queue
// Fetches 32-bit instructions at sequential PCs (one outstanding request),
// buffers them in program order and presents the head to the issue side.
// A flush empties the queue and redirects fetch; a response that belongs to
// a request issued before the flush is discarded.
// Ports:
//   clk_in, rst_in       : clock, synchronous active-high reset
//   rdy_in               : global enable; low freezes all state
//   mem_req_out          : one-cycle fetch request pulse
//   mem_addr_out         : fetch address (valid with mem_req_out)
//   mem_valid_in         : memory response strobe
//   mem_data_in          : fetched instruction
//   issue_ready_in       : consumer accepts the head entry this cycle
//   inst_valid_out       : head entry valid
//   inst_out, pc_out     : head instruction and its PC (zero when empty)
//   flush_in, flush_pc_in: mispredict flush and redirect PC
// ----------------------------------------------------------------------------
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int                QUEUE_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_valid_in,
  input  logic [INST_W-1:0] mem_data_in,
  input  logic              issue_ready_in,
  output logic              inst_valid_out,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] flush_pc_in
);

  localparam int              CNT_W      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              mem_req;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head_entry;
  fetch_entry_t      push_entry;
  logic              queue_valid;
  logic              queue_full;
  logic              do_push;
  logic              do_pop;

  assign queue_valid = (count != {CNT_W{1'b0}});
  assign queue_full  = (count == FULL_COUNT);

  // Flush suppresses both queue operations in its cycle.
  assign do_push = (state == ST_WAIT_MEM) && mem_valid_in && !flush_in;
  assign do_pop  = queue_valid && issue_ready_in && !flush_in;

  assign push_entry.pc   = fetch_pc;
  assign push_entry.inst = mem_data_in;

  instr_queue_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .en         (rdy_in),
    .clear      (flush_in),
    .push       (do_push),
    .pop        (do_pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (count)
  );

  // A pending request pulse is held through a pause and shown once rdy returns.
  assign mem_req_out    = mem_req & rdy_in;
  assign inst_valid_out = queue_valid;
  assign inst_out       = queue_valid ? head_entry.inst : 32'h0000_0000;
  assign pc_out         = queue_valid ? head_entry.pc   : 32'h0000_0000;

  // Fetch FSM, fetch PC and registered request outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      fetch_pc     <= RESET_PC;
      mem_req      <= 1'b0;
      mem_addr_out <= RESET_PC;
    end else if (rdy_in) begin
      mem_req <= 1'b0;
      if (flush_in) begin
        fetch_pc <= flush_pc_in;
        // A response landing in the flush cycle closes the transaction now;
        // otherwise the in-flight one must be swallowed later.
        case (state)
          ST_WAIT_MEM: state <= mem_valid_in ? ST_IDLE : ST_DISCARD;
          ST_DISCARD:  state <= mem_valid_in ? ST_IDLE : ST_DISCARD;
          default:     state <= state;
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            if (!queue_full) begin
              state        <= ST_WAIT_MEM;
              mem_req      <= 1'b1;
              mem_addr_out <= fetch_pc;
            end
          end
          ST_WAIT_MEM: begin
            if (mem_valid_in) begin
              fetch_pc <= next_pc(fetch_pc);
              state    <= ST_IDLE;
            end
          end
          ST_DISCARD: begin
            if (mem_valid_in) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_queue
// Self-checking bench: a table of per-cycle expectations for the first fetches
// after reset, hand-written corner sequences, and a randomized run checked
// against a transaction-level model (expected fetch address, outstanding
// request bookkeeping and a queue of {pc, inst}).
// ----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_valid_in;
  logic [31:0] mem_data_in;
  logic        issue_ready_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        flush_in;
  logic [31:0] flush_pc_in;

  instruction_fetch_queue #(
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_valid_in   (mem_valid_in),
    .mem_data_in    (mem_data_in),
    .issue_ready_in (issue_ready_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .flush_in       (flush_in),
    .flush_pc_in    (flush_pc_in)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { int cyc; logic [31:0] addr; } req_t;
  ent_t q[$];
  req_t req_log[$];

  // model state
  logic [31:0] exp_fetch;
  bit          outstanding;
  bit          cancelled;
  logic [31:0] out_addr;
  int          idle_run;

  // memory model
  bit          mem_pend;
  int          mem_wait;
  int          mem_lat;
  bit          mem_rand;
  bit          mem_fixed;
  logic [31:0] fixed_data;

  // pre-edge samples
  logic        cap_req;
  logic [31:0] cap_addr;
  logic        cap_valid;
  logic [31:0] cap_inst;
  logic [31:0] cap_pc;

  typedef struct {
    bit          iready;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit resp_due();
    return mem_pend && (mem_wait == 0);
  endfunction

  task automatic model_update();
    if (rst_in) begin
      q.delete();
      exp_fetch   = 32'h0000_0000;
      outstanding = 1'b0;
      cancelled   = 1'b0;
      mem_pend    = 1'b0;
      idle_run    = 0;
      return;
    end
    if (!rdy_in) begin
      chk("req_paused", cap_req, 1'b0);
      return;
    end
    if (cap_req) idle_run = 0;
    else if (!flush_in && !outstanding && q.size() < DEPTH) idle_run++;
    chk("req_gap", idle_run <= 1, 1'b1);
    if (cap_req) begin
      chk("req_addr", cap_addr, exp_fetch);
      chk("req_single", outstanding, 1'b0);
      chk("req_room", q.size() < DEPTH, 1'b1);
      req_log.push_back('{cyc, cap_addr});
      outstanding = 1'b1;
      cancelled   = 1'b0;
      out_addr    = cap_addr;
      mem_pend    = 1'b1;
      mem_wait    = (mem_rand ? int'($urandom_range(1, 4)) : mem_lat) - 1;
    end
    if (flush_in) begin
      q.delete();
      exp_fetch = flush_pc_in;
      if (outstanding) begin
        if (mem_valid_in) outstanding = 1'b0;
        else cancelled = 1'b1;
      end
    end else begin
      if (issue_ready_in && q.size() > 0) void'(q.pop_front());
      if (mem_valid_in) begin
        if (!cancelled) begin
          q.push_back('{out_addr, mem_data_in});
          exp_fetch = exp_fetch + 32'd4;
        end
        outstanding = 1'b0;
        cancelled   = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    chk("inst_valid", inst_valid_out, q.size() != 0);
    if (q.size() != 0) begin
      chk("head_pc", pc_out, q[0].pc);
      chk("head_inst", inst_out, q[0].inst);
    end
  endtask

  // One clock: drive memory response, sample outputs, clock, update and check.
  task automatic cycle();
    mem_valid_in = 1'b0;
    mem_data_in  = 32'hDEAD_BEEF;
    if (!rst_in && rdy_in && mem_pend) begin
      if (mem_wait == 0) begin
        mem_valid_in = 1'b1;
        mem_data_in  = mem_fixed ? fixed_data : $urandom();
        mem_pend     = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    #1;
    cap_req   = mem_req_out;
    cap_addr  = mem_addr_out;
    cap_valid = inst_valid_out;
    cap_inst  = inst_out;
    cap_pc    = pc_out;
    @(posedge clk_in);
    #1;
    model_update();
    model_check();
    cyc++;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; flush_pc_in = 32'h0;
    issue_ready_in = 1'b0;
    cycle();
    cycle();
    rst_in = 1'b0;
    req_log.delete();
  endtask

  task automatic run_until_reqs(input int n, input int budget, input string name);
    int k = 0;
    while (req_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk(name, req_log.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t;
    logic        s_valid;
    logic [31:0] s_inst, s_pc, s_addr;

    mem_valid_in = 1'b0; mem_data_in = 32'h0;
    mem_lat = 1; mem_rand = 1'b0; mem_fixed = 1'b1; fixed_data = 32'h0000_0013;

    // Expected per-cycle behaviour after reset, latency-1 memory, consumer ready.
    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13};
    vecs[4] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h4, 1'b1, 32'h4, 32'h13};
    vecs[7] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 32'h13};

    // Reset state
    do_reset();
    chk("rst_mem_req", mem_req_out, 1'b0);
    chk("rst_mem_addr", mem_addr_out, 32'h0);
    chk("rst_inst_valid", inst_valid_out, 1'b0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);

    // Table-driven first fetches
    for (int i = 0; i < 10; i++) begin
      issue_ready_in = vecs[i].iready;
      cycle();
      chk($sformatf("t1_req[%0d]", i), cap_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk($sformatf("t1_addr[%0d]", i), cap_addr, vecs[i].exp_addr);
      chk($sformatf("t1_valid[%0d]", i), cap_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("t1_pc[%0d]", i), cap_pc, vecs[i].exp_pc);
        chk($sformatf("t1_inst[%0d]", i), cap_inst, vecs[i].exp_inst);
      end
    end

    // Fill to depth with consumer stalled, then a single pop
    mem_fixed = 1'b0;
    do_reset();
    issue_ready_in = 1'b0;
    for (int i = 0; i < 80; i++) cycle();
    chk("t2_req_count", req_log.size(), 16);
    chk("t2_last_addr", req_log[req_log.size()-1].addr, 32'd60);
    chk("t2_head_pc", pc_out, 32'h0);
    issue_ready_in = 1'b1;
    t = cyc;
    cycle();
    issue_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("t2_req_after_pop", req_log.size(), 17);
    chk("t2_addr_after_pop", req_log[req_log.size()-1].addr, 32'd64);
    chk("t2_req_cycle", req_log[req_log.size()-1].cyc, t + 2);
    chk("t2_head_after_pop", pc_out, 32'h4);

    // Flush during WAIT_MEM; response arrives three cycles later
    mem_lat = 4;
    do_reset();
    run_until_reqs(1, 10, "t3_first_req");
    t = req_log[0].cyc;
    flush_in = 1'b1; flush_pc_in = 32'h0000_0100;
    cycle();
    flush_in = 1'b0;
    run_until_reqs(2, 20, "t3_second_req");
    chk("t3_redirect_addr", req_log[req_log.size()-1].addr, 32'h100);
    chk("t3_redirect_cycle", req_log[req_log.size()-1].cyc, t + 6);
    chk("t3_no_push", inst_valid_out, 1'b0);
    for (int i = 0; i < 6; i++) cycle();

    // Flush coincident with a response and a pop
    mem_lat = 1;
    do_reset();
    run_until_reqs(2, 20, "t4_two_reqs");
    chk("t4_resp_due", resp_due(), 1'b1);
    chk("t4_head_before", inst_valid_out, 1'b1);
    flush_in = 1'b1; flush_pc_in = 32'h0000_0200; issue_ready_in = 1'b1;
    t = cyc;
    cycle();
    flush_in = 1'b0; issue_ready_in = 1'b0;
    chk("t4_empty", inst_valid_out, 1'b0);
    run_until_reqs(3, 20, "t4_third_req");
    chk("t4_redirect_addr", req_log[req_log.size()-1].addr, 32'h200);
    chk("t4_redirect_cycle", req_log[req_log.size()-1].cyc, t + 2);
    cycle();
    chk("t4_new_head_valid", inst_valid_out, 1'b1);
    chk("t4_new_head_pc", pc_out, 32'h200);

    // Pause for five cycles while a request pulse is pending
    mem_lat = 2;
    do_reset();
    issue_ready_in = 1'b1;
    k = 0;
    while (!(req_log.size() >= 2 && resp_due()) && k < 50) begin
      cycle();
      k++;
    end
    cycle();
    issue_ready_in = 1'b0;
    cycle();
    s_valid = inst_valid_out; s_inst = inst_out; s_pc = pc_out; s_addr = mem_addr_out;
    chk("t5_head_valid", s_valid, 1'b1);
    rdy_in = 1'b0; issue_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_pause_req", cap_req, 1'b0);
      chk("t5_pause_addr", cap_addr, s_addr);
      chk("t5_pause_valid", cap_valid, s_valid);
      chk("t5_pause_pc", cap_pc, s_pc);
      chk("t5_pause_inst", cap_inst, s_inst);
    end
    rdy_in = 1'b1;
    cycle();
    chk("t5_resume_req", cap_req, 1'b1);
    chk("t5_resume_addr", cap_addr, s_addr);
    for (int i = 0; i < 30; i++) cycle();
    for (int i = 0; i < req_log.size(); i++)
      chk($sformatf("t5_seq[%0d]", i), req_log[i].addr, 32'(4 * i));

    // Simultaneous push and pop at count 15 (tail wraps 15 -> 0)
    mem_lat = 1;
    do_reset();
    k = 0;
    while (!(q.size() == 15 && resp_due()) && k < 100) begin
      cycle();
      k++;
    end
    chk("t6_filled", inst_valid_out, 1'b1);
    issue_ready_in = 1'b1;
    cycle();
    issue_ready_in = 1'b0;
    chk("t6_head_pc", pc_out, 32'h4);
    run_until_reqs(17, 10, "t6_req_after");
    chk("t6_req_addr", req_log[req_log.size()-1].addr, 32'd64);
    issue_ready_in = 1'b1;
    for (int i = 0; i < 100; i++) cycle();

    // Randomized run against the model
    mem_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_in         = (i == 1500);
      rdy_in         = ($urandom_range(0, 9) != 0);
      issue_ready_in = ((i % 1000) < 500) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
      flush_in       = rdy_in && ($urandom_range(0, 29) == 0);
      flush_pc_in    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                   : ($urandom() & 32'hFFFF_FFFC);
      cycle();
    end
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
